mem_lane_ctrl: RTL and testbench

MEM_LANE_CTRL -- requirements
Module: mem_lane_ctrl

---
 rtl/mem_lane_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_lane_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lane_ctrl.sv
// mem_lane_ctrl: CPU load/store front end for a 32-bit word RAM split
// into two 16-bit byte lanes (lo = bytes 0,1; hi = bytes 2,3).
// Ports: clk/rst (sync, active-high); req_* CPU request (valid/ready);
// rsp_* one-cycle response pulse; ram_* lane RAM port (q combinational).
module mem_lane_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_sel_lo,
  output logic              ram_sel_hi,
  output logic [15:0]       ram_d_lo,
  output logic [15:0]       ram_d_hi,
  input  logic [15:0]       ram_q_lo,
  input  logic [15:0]       ram_q_hi
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state;
  logic              we_r;
  logic              sign_r;
  logic              err_r;
  logic [1:0]        size_r;
  logic [1:0]        off_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       cap_r;

  logic              req_err;
  logic [15:0]       lane;
  logic [31:0]       shifted;

  always_comb begin
    unique case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_r    <= 1'b0;
      sign_r  <= 1'b0;
      err_r   <= 1'b0;
      size_r  <= 2'b00;
      off_r   <= 2'b00;
      waddr_r <= '0;
      wdata_r <= '0;
      cap_r   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_r    <= req_we;
            sign_r  <= req_sign;
            err_r   <= req_err;
            size_r  <= req_size;
            off_r   <= req_addr[1:0];
            waddr_r <= req_addr[ADDR_W+1:2];
            wdata_r <= req_wdata;
            // byte stores need the old lane for the merge
            if (req_err)
              state <= RESP;
            else if (!req_we || req_size == 2'b00)
              state <= RD;
            else
              state <= WR;
          end
        end
        RD: begin
          cap_r <= {ram_q_hi, ram_q_lo};
          state <= we_r ? WR : RESP;
        end
        WR:      state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    rsp_valid  = (state == RESP);
    rsp_err    = (state == RESP) && err_r;
    rsp_rdata  = '0;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_sel_lo = 1'b0;
    ram_sel_hi = 1'b0;
    ram_d_lo   = '0;
    ram_d_hi   = '0;
    lane       = off_r[1] ? cap_r[31:16] : cap_r[15:0];
    shifted    = cap_r >> {off_r, 3'b000};

    if (state == RD || state == WR)
      ram_addr = waddr_r;

    if (state == WR) begin
      ram_we = 1'b1;
      unique case (size_r)
        2'b10: begin
          ram_sel_lo = 1'b1;
          ram_sel_hi = 1'b1;
          ram_d_lo   = wdata_r[15:0];
          ram_d_hi   = wdata_r[31:16];
        end
        2'b01: begin
          ram_sel_lo = ~off_r[1];
          ram_sel_hi = off_r[1];
          ram_d_lo   = off_r[1] ? 16'h0 : wdata_r[15:0];
          ram_d_hi   = off_r[1] ? wdata_r[15:0] : 16'h0;
        end
        default: begin
          if (off_r[0])
            lane[15:8] = wdata_r[7:0];
          else
            lane[7:0] = wdata_r[7:0];
          ram_sel_lo = ~off_r[1];
          ram_sel_hi = off_r[1];
          ram_d_lo   = off_r[1] ? 16'h0 : lane;
          ram_d_hi   = off_r[1] ? lane : 16'h0;
        end
      endcase
    end

    if (state == RESP && !err_r && !we_r) begin
      unique case (size_r)
        2'b00:
          rsp_rdata = {{24{sign_r & shifted[7]}}, shifted[7:0]};
        2'b01:
          rsp_rdata = {{16{sign_r & shifted[15]}}, shifted[15:0]};
        default:
          rsp_rdata = cap_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lane_ctrl.sv
// tb_mem_lane_ctrl: directed and random load/store checks of
// mem_lane_ctrl against a flat word-array reference memory.
module tb_mem_lane_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic        ram_sel_lo;
  logic        ram_sel_hi;
  logic [15:0] ram_d_lo;
  logic [15:0] ram_d_hi;
  logic [15:0] ram_q_lo;
  logic [15:0] ram_q_hi;

  bit [31:0] mem  [0:1023];
  bit [31:0] refm [0:1023];

  int tests = 0;
  int fails = 0;

  logic [9:0]  wr_addr;
  logic        wr_lo, wr_hi;
  logic [15:0] wr_dlo, wr_dhi;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  mem_lane_ctrl #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_sel_lo(ram_sel_lo), .ram_sel_hi(ram_sel_hi),
    .ram_d_lo(ram_d_lo), .ram_d_hi(ram_d_hi),
    .ram_q_lo(ram_q_lo), .ram_q_hi(ram_q_hi)
  );

  assign {ram_q_hi, ram_q_lo} = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_we) begin
      if (ram_sel_lo) mem[ram_addr][15:0]  <= ram_d_lo;
      if (ram_sel_hi) mem[ram_addr][31:16] <= ram_d_hi;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz,
                        input logic sg, input logic [11:0] a,
                        input logic [31:0] wd, input string tag);
    int w, off, n, wes, exp_lat, exp_wes;
    bit err, got, act;
    logic [31:0] word, v, mask, exp_rd;
    w   = int'(a[11:2]);
    off = int'(a[1:0]);
    err = (sz == 3) || (sz == 1 && off % 2 == 1) || (sz == 2 && off != 0);
    exp_lat = err ? 1 : (!we ? 2 : (sz == 0 ? 3 : 2));
    exp_wes = (err || !we) ? 0 : 1;
    exp_rd  = 0;
    mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (!err && !we) begin
      word = refm[w];
      v = (word >> (8 * off)) & mask;
      if (sg && sz == 0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      if (sg && sz == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      exp_rd = v;
    end
    @(negedge clk);
    chk({tag, ".rdy"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = sz;
    req_sign = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    n = 0; got = 0; wes = 0; act = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) req_valid = 1'b0;
      if (ram_we || ram_sel_lo || ram_sel_hi || ram_addr != 0) act = 1;
      if (ram_we) begin
        wes++;
        wr_addr = ram_addr; wr_lo = ram_sel_lo; wr_hi = ram_sel_hi;
        wr_dlo = ram_d_lo; wr_dhi = ram_d_hi;
      end
      if (rsp_valid) got = 1;
      else chk({tag, ".idle0"}, {rsp_rdata[30:0], rsp_err}, 0);
    end
    last_rdata = rsp_rdata;
    chk({tag, ".lat"}, n, exp_lat);
    chk({tag, ".err"}, rsp_err, err);
    chk({tag, ".rdata"}, rsp_rdata, exp_rd);
    chk({tag, ".wes"}, wes, exp_wes);
    if (err) chk({tag, ".noacc"}, act, 0);
    if (!err && we) begin
      refm[w] = (refm[w] & ~(mask << (8 * off))) |
                ((wd & mask) << (8 * off));
      chk({tag, ".mem"}, mem[w], refm[w]);
    end
  endtask

  initial begin
    int n;
    bit bad;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", req_ready, 1);
    chk("rst.rsp", {rsp_valid, rsp_err}, 0);
    chk("rst.rdata", rsp_rdata, 0);
    chk("rst.ram", {ram_addr, ram_we, ram_sel_lo, ram_sel_hi}, 0);
    chk("rst.d", {ram_d_hi, ram_d_lo}, 0);
    rst = 1'b0;

    do_req(1, 2'b10, 0, 12'h010, 32'hA1B2C3D4, "wst");
    chk("wst.addr", wr_addr, 4);
    chk("wst.sel", {wr_hi, wr_lo}, 2'b11);
    chk("wst.dhi", wr_dhi, 16'hA1B2);
    chk("wst.dlo", wr_dlo, 16'hC3D4);

    do_req(1, 2'b00, 0, 12'h012, 32'h000000EE, "bst");
    chk("bst.sel", {wr_hi, wr_lo}, 2'b10);
    chk("bst.dhi", wr_dhi, 16'hA1EE);
    do_req(0, 2'b10, 0, 12'h010, 0, "wld");
    chk("wld.val", last_rdata, 32'hA1EEC3D4);

    do_req(1, 2'b10, 0, 12'h010, 32'h80000000, "wst2");
    do_req(0, 2'b00, 1, 12'h013, 0, "lbs");
    chk("lbs.val", last_rdata, 32'hFFFFFF80);
    do_req(0, 2'b00, 0, 12'h013, 0, "lbu");
    chk("lbu.val", last_rdata, 32'h00000080);

    do_req(0, 2'b01, 0, 12'h011, 0, "herr");

    // reset while the byte store sits in RD
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
    req_addr = 12'h012; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rrd.ready", req_ready, 1);
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      if (ram_we || rsp_valid) bad = 1;
      @(negedge clk);
    end
    chk("rrd.quiet", bad, 0);
    chk("rrd.mem", mem[4], refm[4]);
    do_req(0, 2'b10, 0, 12'h010, 0, "rrd.ld");

    // back-to-back with req_valid held
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 12'h020; req_wdata = 32'h11223344;
    @(posedge clk);
    n = 0; bad = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_we = 1'b0; req_addr = 12'h020; req_wdata = 0;
      end
      if (req_ready) bad = 1;
      if (rsp_valid) break;
    end
    chk("b2b.lat1", n, 2);
    chk("b2b.busy", bad, 0);
    refm[8] = 32'h11223344;
    @(negedge clk);
    chk("b2b.ready", req_ready, 1);
    @(posedge clk);
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) req_valid = 1'b0;
      if (rsp_valid) break;
    end
    chk("b2b.lat2", n, 2);
    chk("b2b.rdata", rsp_rdata, 32'h11223344);

    // reset beats a simultaneous request
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1;
    req_size = 2'b10; req_addr = 12'h030; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    chk("rpri.ready", req_ready, 1);
    bad = 0;
    repeat (4) begin
      if (ram_we || rsp_valid) bad = 1;
      @(negedge clk);
    end
    chk("rpri.quiet", bad, 0);
    chk("rpri.mem", mem[12], 0);

    for (int i = 0; i < 80; i++) begin
      do_req(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
             12'($urandom % 64), $urandom, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
